// File: rtl/alu_pkg.sv
// ALU opcode definitions shared by the ALU arbiter.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND = 4'd0;
    localparam alu_op_t ALU_OR  = 4'd1;
    localparam alu_op_t ALU_ADD = 4'd2;
    localparam alu_op_t ALU_SLL = 4'd3;
    localparam alu_op_t ALU_SRL = 4'd4;
    localparam alu_op_t ALU_SUB = 4'd6;
    localparam alu_op_t ALU_SLT = 4'd7;
    localparam alu_op_t ALU_NOR = 4'd12;

    // True for opcodes the ALU actually implements.
    function automatic logic alu_op_legal(input alu_op_t op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SLL,
            ALU_SRL, ALU_SUB, ALU_SLT, ALU_NOR: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin grant logic with its priority pointer register.
// Scans upward from the pointer with wrap; the pointer moves past each winner.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_ptr_next;
    logic [ID_W-1:0] cand;

    // First valid requester at or after rr_ptr wins; nothing is granted during reset.
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_valid && !reset && req[cand]) begin
                gnt_valid = 1'b1;
                gnt[cand] = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    // Pointer moves to the requester after the winner, wrapping at NUM_REQ.
    always_comb begin
        rr_ptr_next = rr_ptr;
        if (gnt_valid) begin
            rr_ptr_next = (32'(gnt_id) + 1 >= NUM_REQ) ? '0 : gnt_id + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between NUM_REQ requesters.
// Accept edge -> issue register drives the ALU -> response register, 2 cycles
// latency at one operation per cycle.
// Optional: define ALU_ARB_ILLEGAL_OP_EN to add the resp_illegal output.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned  NUM_REQ = 2,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    input  logic [NUM_REQ*4-1:0]    req_op,
    output logic [31:0]             alu_a,
    output logic [31:0]             alu_b,
    output logic [3:0]              alu_op,
    input  logic [31:0]             alu_result,
    input  logic                    alu_zero,
    output logic                    resp_valid,
    output logic [ID_W-1:0]         resp_id,
    output logic [31:0]             resp_result,
    output logic                    resp_zero
`ifdef ALU_ARB_ILLEGAL_OP_EN
    ,
    output logic                    resp_illegal
`endif
);

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_valid;

    logic [31:0]        win_a;
    logic [31:0]        win_b;
    alu_op_t            win_op;

    logic               iss_valid;
    logic [31:0]        iss_a;
    logic [31:0]        iss_b;
    alu_op_t            iss_op;
    logic [ID_W-1:0]    iss_id;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    // Grant is one-hot, so it doubles as the ready vector.
    assign req_ready = gnt;

    // One-hot operand mux selecting the winner's fields.
    always_comb begin
        win_a  = '0;
        win_b  = '0;
        win_op = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt[i]) begin
                win_a  = req_a[32*i +: 32];
                win_b  = req_b[32*i +: 32];
                win_op = req_op[4*i +: 4];
            end
        end
    end

    // Issue stage: capture the accepted request; data holds when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            iss_valid <= 1'b0;
            iss_a     <= '0;
            iss_b     <= '0;
            iss_op    <= '0;
            iss_id    <= '0;
        end else begin
            iss_valid <= gnt_valid;
            if (gnt_valid) begin
                iss_a  <= win_a;
                iss_b  <= win_b;
                iss_op <= win_op;
                iss_id <= gnt_id;
            end
        end
    end

    assign alu_a  = iss_a;
    assign alu_b  = iss_b;
    assign alu_op = iss_op;

    // Response stage: register the ALU outcome for the issued operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
        end else begin
            resp_valid <= iss_valid;
            if (iss_valid) begin
                resp_result <= alu_result;
                resp_zero   <= alu_zero;
                resp_id     <= iss_id;
            end
        end
    end

`ifdef ALU_ARB_ILLEGAL_OP_EN
    // Flag opcodes the ALU does not implement, aligned with resp_result.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_illegal <= 1'b0;
        end else if (iss_valid) begin
            resp_illegal <= !alu_op_legal(iss_op);
        end
    end
`else
    // Without the illegal-op flag, opcodes pass through unchecked.
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (NUM_REQ = 2) with a
// behavioural ALU attached to the alu_* ports.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [7:0]  req_op = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        resp_valid;
    logic [0:0]  resp_id;
    logic [31:0] resp_result;
    logic        resp_zero;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic        resp_illegal;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .NUM_REQ (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero)
`ifdef ALU_ARB_ILLEGAL_OP_EN
        ,
        .resp_illegal(resp_illegal)
`endif
    );

    // Behavioural ALU; undefined opcodes give 0.
    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_a & alu_b;
            4'd1:    alu_result = alu_a | alu_b;
            4'd2:    alu_result = alu_a + alu_b;
            4'd3:    alu_result = alu_a << alu_b[4:0];
            4'd4:    alu_result = alu_a >> alu_b[4:0];
            4'd6:    alu_result = alu_a - alu_b;
            4'd7:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd12:   alu_result = ~(alu_a | alu_b);
            default: alu_result = 32'd0;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
        req_op[4*idx +: 4]  = op;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 3) reset = 1'b0;
            #1;
            n_vec++;
            if (resp_valid !== 1'b0) begin
                n_miss++;
                $display("FAIL reset_resp_valid c=%0d got %b want 0", c, resp_valid);
            end
            n_vec++;
            if (req_ready !== 2'b00) begin
                n_miss++;
                $display("FAIL reset_req_ready c=%0d got %b want 00", c, req_ready);
            end
            n_vec++;
            if (alu_op !== 4'd0) begin
                n_miss++;
                $display("FAIL reset_alu_op c=%0d got %0d want 0", c, alu_op);
            end
        end
        n_vec++;
        if ({alu_a, alu_b, resp_result, resp_id, resp_zero} !== '0) begin
            n_miss++;
            $display("FAIL reset_regs got a=%h b=%h res=%h id=%0d z=%b want all 0",
                     alu_a, alu_b, resp_result, resp_id, resp_zero);
        end
    endtask

    task automatic test_single();
        set_req(0, 32'd5, 32'd3, 4'd2);
        @(negedge clk);
        req_valid = 2'b01;
        #1;
        n_vec++;
        if (req_ready !== 2'b01) begin
            n_miss++;
            $display("FAIL single_ready got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_vec++;
        if (resp_valid !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 4'd2) begin
            n_miss++;
            $display("FAIL single_issue got rv=%b a=%0d b=%0d op=%0d want rv=0 a=5 b=3 op=2",
                     resp_valid, alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_result !== 32'd8 ||
            resp_zero !== 1'b0) begin
            n_miss++;
            $display("FAIL single_resp got rv=%b id=%0d res=%0d z=%b want rv=1 id=0 res=8 z=0",
                     resp_valid, resp_id, resp_result, resp_zero);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (resp_valid !== 1'b0 || resp_result !== 32'd8) begin
            n_miss++;
            $display("FAIL single_after got rv=%b res=%0d want rv=0 res=8",
                     resp_valid, resp_result);
        end
    endtask

    task automatic test_both();
        logic [1:0]  exp_rdy [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        logic [0:0]  exp_id  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exp_res [6] = '{32'd0, 32'd16, 32'd0, 32'd16, 32'd0, 32'd16};
        logic        exp_z   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        exp_rv;
        do_reset();
        set_req(0, 32'd7, 32'd7, 4'd6);
        set_req(1, 32'd1, 32'd4, 4'd3);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            req_valid = (c < 6) ? 2'b11 : 2'b00;
            #1;
            if (c < 6) begin
                n_vec++;
                if (req_ready !== exp_rdy[c]) begin
                    n_miss++;
                    $display("FAIL both_ready c=%0d got %b want %b", c, req_ready, exp_rdy[c]);
                end
            end
            exp_rv = (c >= 2 && c < 8);
            n_vec++;
            if (resp_valid !== exp_rv) begin
                n_miss++;
                $display("FAIL both_resp_valid c=%0d got %b want %b", c, resp_valid, exp_rv);
            end
            if (exp_rv) begin
                n_vec++;
                if (resp_id !== exp_id[c-2] || resp_result !== exp_res[c-2] ||
                    resp_zero !== exp_z[c-2]) begin
                    n_miss++;
                    $display("FAIL both_resp c=%0d got id=%0d res=%0d z=%b want id=%0d res=%0d z=%b",
                             c, resp_id, resp_result, resp_zero,
                             exp_id[c-2], exp_res[c-2], exp_z[c-2]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_rv;
        set_req(1, 32'h0000_00F0, 32'h0000_000F, 4'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = (c < 3) ? 2'b10 : 2'b00;
            #1;
            if (c < 3) begin
                n_vec++;
                if (req_ready !== 2'b10) begin
                    n_miss++;
                    $display("FAIL b2b_ready c=%0d got %b want 10", c, req_ready);
                end
            end
            exp_rv = (c >= 2 && c < 5);
            n_vec++;
            if (resp_valid !== exp_rv) begin
                n_miss++;
                $display("FAIL b2b_resp_valid c=%0d got %b want %b", c, resp_valid, exp_rv);
            end
            if (exp_rv) begin
                n_vec++;
                if (resp_id !== 1'b1 || resp_result !== 32'h0000_00FF || resp_zero !== 1'b0) begin
                    n_miss++;
                    $display("FAIL b2b_resp c=%0d got id=%0d res=%h z=%b want id=1 res=000000ff z=0",
                             c, resp_id, resp_result, resp_zero);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        set_req(0, 32'd5, 32'd3, 4'd2);
        set_req(1, 32'd1, 32'd4, 4'd3);
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        n_vec++;
        if (req_ready !== 2'b01) begin
            n_miss++;
            $display("FAIL rmid_first_ready got %b want 01", req_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 2'b00) begin
            n_miss++;
            $display("FAIL rmid_ready_in_reset got %b want 00", req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if (resp_valid !== 1'b0 || alu_op !== 4'd0) begin
            n_miss++;
            $display("FAIL rmid_flushed got rv=%b op=%0d want rv=0 op=0", resp_valid, alu_op);
        end
        n_vec++;
        if (req_ready !== 2'b01) begin
            n_miss++;
            $display("FAIL rmid_ready_after got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_vec++;
        if (resp_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL rmid_no_stale_resp got %b want 0", resp_valid);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_result !== 32'd8) begin
            n_miss++;
            $display("FAIL rmid_resp got rv=%b id=%0d res=%0d want rv=1 id=0 res=8",
                     resp_valid, resp_id, resp_result);
        end
    endtask

    task automatic test_illegal_op();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) set_req(0, 32'd3, 32'd4, 4'd9);
            if (c == 1) set_req(0, 32'd0, 32'd0, 4'd12);
            req_valid = (c < 2) ? 2'b01 : 2'b00;
            #1;
            if (c < 2) begin
                n_vec++;
                if (req_ready !== 2'b01) begin
                    n_miss++;
                    $display("FAIL illop_ready c=%0d got %b want 01", c, req_ready);
                end
            end
            if (c == 2) begin
                n_vec++;
                if (resp_valid !== 1'b1 || resp_result !== 32'd0 || resp_zero !== 1'b1) begin
                    n_miss++;
                    $display("FAIL illop_op9 got rv=%b res=%h z=%b want rv=1 res=0 z=1",
                             resp_valid, resp_result, resp_zero);
                end
`ifdef ALU_ARB_ILLEGAL_OP_EN
                n_vec++;
                if (resp_illegal !== 1'b1) begin
                    n_miss++;
                    $display("FAIL illop_flag9 got %b want 1", resp_illegal);
                end
`endif
            end
            if (c == 3) begin
                n_vec++;
                if (resp_valid !== 1'b1 || resp_result !== 32'hFFFF_FFFF || resp_zero !== 1'b0) begin
                    n_miss++;
                    $display("FAIL illop_nor got rv=%b res=%h z=%b want rv=1 res=ffffffff z=0",
                             resp_valid, resp_result, resp_zero);
                end
`ifdef ALU_ARB_ILLEGAL_OP_EN
                n_vec++;
                if (resp_illegal !== 1'b0) begin
                    n_miss++;
                    $display("FAIL illop_flag12 got %b want 0", resp_illegal);
                end
`endif
            end
            if (c == 4) begin
                n_vec++;
                if (resp_valid !== 1'b0 || alu_op !== 4'd12) begin
                    n_miss++;
                    $display("FAIL illop_idle got rv=%b op=%0d want rv=0 op=12",
                             resp_valid, alu_op);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_back_to_back();
        test_reset_mid();
        test_illegal_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Round-robin arbiter that shares the single 32-bit ALU between NUM_REQ requesters, for example the EX stage, the address-generation path and the branch-compare path.
- Each requester presents operands and an opcode through a valid/ready handshake.
- The winning request is registered, driven onto the ALU ports, and the result is registered back.
- A tagged response comes out two cycles after acceptance, at a throughput of one operation per cycle.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, derived localparam = (NUM_REQ>1) ? $clog2(NUM_REQ) : 1, width of the requester tag

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
req_a  input  NUM_REQ*32  operand A; requester i occupies bits [32i+31:32i]
req_b  input  NUM_REQ*32  operand B, same packing as req_a
req_op  input  NUM_REQ*4  ALU opcode, packed 4 bits per requester
alu_a  output  32  operand A to the ALU
alu_b  output  32  operand B to the ALU
alu_op  output  4  opcode to the ALU
alu_result  input  32  ALU result (combinational)
alu_zero  input  1  ALU zero flag
resp_valid  output  1  response valid, single-cycle pulse per operation
resp_id  output  ID_W  index of the requester that owns the response
resp_result  output  32  registered ALU result
resp_zero  output  1  registered zero flag

Behaviour:
- Reset (synchronous, active-high) clears:
  - rr_ptr to 0.
  - Issue-stage registers: iss_valid=0, iss_a/iss_b=0, iss_op=0, iss_id=0.
  - Response registers: resp_valid=0, resp_id=0, resp_result=0, resp_zero=0.
  - req_ready is 0 while reset is high.
- Arbitration (combinational, cycle N):
  - Scan requesters starting at rr_ptr, upward with wrap modulo NUM_REQ.
  - The first requester with req_valid=1 wins, and req_ready[winner]=1.
  - All other req_ready bits are 0; all bits are 0 if no request is valid.
  - req_ready may depend combinationally on req_valid.
  - No response backpressure exists, so a grant is always possible when any request is valid.
- Handshake:
  - A transfer occurs on a rising edge where req_valid[i] & req_ready[i].
  - A requester holds a, b and op stable while valid and not ready.
  - Deasserting valid before the grant is permitted; the request is simply dropped.
- Pointer update:
  - On a transfer, rr_ptr <= (winner+1) mod NUM_REQ.
  - With no transfer, rr_ptr holds its value.
- Issue stage (cycle N+1):
  - On a transfer: iss_valid<=1, and iss_a/iss_b/iss_op/iss_id take the winner's values.
  - Otherwise iss_valid<=0 and the data registers hold their values.
  - alu_a=iss_a, alu_b=iss_b, alu_op=iss_op at all times; inputs stay static when idle.
- Response stage (cycle N+2):
  - resp_valid<=iss_valid.
  - When iss_valid=1: resp_result<=alu_result, resp_zero<=alu_zero, resp_id<=iss_id.
  - When iss_valid=0, the data registers hold their values.
- Latency and throughput:
  - Latency from accept edge to resp_valid is 2 cycles.
  - Back-to-back grants produce back-to-back responses in grant order.
- Opcodes are passed through unmodified. Undefined opcodes (5, 8–11, 13–15) yield the ALU's result of 0 with zero=1.
- Boundary conditions:
  - All requesters valid: strict rotation 0,1,…,NUM_REQ-1,0.
  - A single valid requester is granted every cycle.
  - NUM_REQ=1 degenerates to always granting requester 0, with resp_id=0.
- Reset mid-operation: in-flight issue and response entries are discarded and no resp_valid is emitted for them.

Optional Feature:
Macro ALU_ARB_ILLEGAL_OP_EN.
- Defined:
  - Adds output resp_illegal (1 bit), registered alongside resp_result and reset to 0.
  - resp_illegal=1 when the issued opcode is not in {0,1,2,3,4,6,7,12}.
  - The result path is unchanged.
- Undefined: the port and its logic are absent.

Decomposition:
- Package alu_pkg holds:
  - typedef alu_op_t (logic [3:0]).
  - Constants ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SLL=3, ALU_SRL=4, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12.
  - Function alu_op_legal().
- One sub-module, rr_arbiter: generic NUM_REQ round-robin grant logic with the pointer register. The issue and response pipeline stays in alu_arbiter.

Test Plan:
1. Reset held 3 cycles, then released with no requests -> resp_valid=0, req_ready=0, alu_op=0 throughout.
2. Requester 0 sends a=5, b=3, op=2 -> req_ready[0]=1 in the same cycle; resp_valid=1 two cycles later with resp_id=0, resp_result=8, resp_zero=0.
3. Both requesters valid continuously for 6 cycles:
   - Requester 0: a=7, b=7, op=6.
   - Requester 1: a=1, b=4, op=3.
   - Expected grants in order 0,1,0,1,0,1.
   - Expected responses alternate result 0 with zero=1, and result 16 with zero=0.
4. Requester 1 alone is valid for 3 cycles (a=0xF0, b=0x0F, op=1) -> 3 consecutive grants, then 3 consecutive responses with result 0xFF and id=1.
5. Reset asserted the cycle after a grant -> no resp_valid afterwards; the next grant after reset goes to requester 0 when both are valid.
6. With ALU_ARB_ILLEGAL_OP_EN defined, send op=9 -> resp_illegal=1, resp_result=0, resp_zero=1; then send op=12 with a=0, b=0 -> resp_illegal=0, resp_result=0xFFFFFFFF.
